// File: rtl/simon_bus_pkg.sv
// Shared types and word-count constants for the SIMON 96/96 bus adapter.
package simon_bus_pkg;

  localparam int P_N = 48;
  localparam int P_M = 2;
  localparam int P_W = 16;
  localparam int DW  = (2 * P_N) / P_W;
  localparam int KW  = (P_M * P_N) / P_W;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    OFFER_D = 2'd1,
    OFFER_K = 2'd2
  } in_state_t;

  typedef enum logic {
    O_IDLE = 1'b0,
    O_SEND = 1'b1
  } out_state_t;

  function automatic int cnt_width(input int words);
    return (words < 1) ? 1 : $clog2(words + 1);
  endfunction

endpackage

// File: rtl/simon_word_shifter.sv
// Parallel-load, right-shifting word unpacker; flags when the current word is the last one.
module simon_word_shifter
  import simon_bus_pkg::*;
#(
  parameter int WIDTH = 96,
  parameter int W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             shift,
  output logic [W-1:0]     word,
  output logic             last
);

  localparam int WORDS = WIDTH / W;
  localparam int CW    = cnt_width(WORDS);

  logic [WIDTH-1:0] sh_r;
  logic [CW-1:0]    cnt_r;

  // shift register and transferred-word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_r  <= {WIDTH{1'b0}};
      cnt_r <= {CW{1'b0}};
    end else if (load) begin
      sh_r  <= load_data;
      cnt_r <= {CW{1'b0}};
    end else if (shift) begin
      sh_r  <= {{W{1'b0}}, sh_r[WIDTH-1:W]};
      cnt_r <= cnt_r + CW'(1'b1);
    end else begin
      sh_r  <= sh_r;
      cnt_r <= cnt_r;
    end
  end

  assign word = sh_r[W-1:0];
  assign last = (cnt_r == CW'(WORDS - 1));

endmodule

// File: rtl/simon_bus_adapter.sv
// Word-serial front end for the SIMON 96/96 core: packs plaintext/key bursts,
// offers them to the core, and streams the ciphertext back out word by word.
module simon_bus_adapter
  import simon_bus_pkg::*;
#(
  parameter int N = P_N,
  parameter int M = P_M,
  parameter int W = P_W
) (
  input  logic           clk,
  input  logic           nR,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_kind,
  input  logic           in_enc_dec,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           newData,
  output logic           newKey,
  input  logic           ldData,
  input  logic           ldKey,
  output logic           enc_dec,
  output logic [2*N-1:0] plain,
  output logic [M*N-1:0] key,
  input  logic           doneData,
  output logic           readData,
  input  logic [2*N-1:0] cipher
);

  localparam int DATA_WORDS = (2 * N) / W;
  localparam int KEY_WORDS  = (M * N) / W;
  localparam int MAX_WORDS  = (DATA_WORDS > KEY_WORDS) ? DATA_WORDS : KEY_WORDS;
  localparam int CW         = cnt_width(MAX_WORDS);

  in_state_t      in_state_r, in_state_s;
  out_state_t     o_state_r, o_state_s;
  logic [CW-1:0]  cnt_r, idx_s;
  logic           kind_r, accept_s, restart_s, last_in_s;
  logic [2*N-1:0] plain_r;
  logic [M*N-1:0] key_r;
  logic           enc_dec_r, new_data_r, new_key_r, read_data_r, out_valid_r;
  logic           sh_load_s, sh_shift_s, sh_last_s;
  logic [W-1:0]   sh_word_s;

  // input FSM next state; a kind change mid-burst restarts the burst at slot 0
  always_comb begin
    in_state_s = in_state_r;
    accept_s   = 1'b0;
    restart_s  = 1'b0;
    idx_s      = cnt_r;
    last_in_s  = 1'b0;
    case (in_state_r)
      COLLECT: begin
        accept_s  = in_valid;
        restart_s = (cnt_r != {CW{1'b0}}) && (in_kind != kind_r);
        if (restart_s) idx_s = {CW{1'b0}};
        else           idx_s = cnt_r;
        if (in_kind) last_in_s = (idx_s == CW'(KEY_WORDS - 1));
        else         last_in_s = (idx_s == CW'(DATA_WORDS - 1));
        if (accept_s && last_in_s) in_state_s = in_kind ? OFFER_K : OFFER_D;
        else                       in_state_s = COLLECT;
      end
      OFFER_D: begin
        if (ldData) in_state_s = COLLECT;
        else        in_state_s = OFFER_D;
      end
      OFFER_K: begin
        if (ldKey) in_state_s = COLLECT;
        else       in_state_s = OFFER_K;
      end
      default: in_state_s = COLLECT;
    endcase
  end

  // input FSM state register
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) in_state_r <= COLLECT;
    else     in_state_r <= in_state_s;
  end

  // burst assembly registers and offer strobes
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      cnt_r      <= {CW{1'b0}};
      kind_r     <= 1'b0;
      plain_r    <= {(2*N){1'b0}};
      key_r      <= {(M*N){1'b0}};
      enc_dec_r  <= 1'b0;
      new_data_r <= 1'b0;
      new_key_r  <= 1'b0;
    end else begin
      new_data_r <= (in_state_s == OFFER_D);
      new_key_r  <= (in_state_s == OFFER_K);
      if (accept_s) begin
        kind_r <= in_kind;
        cnt_r  <= last_in_s ? {CW{1'b0}} : (idx_s + CW'(1'b1));
        if (in_kind) begin
          for (int i = 0; i < KEY_WORDS; i++)
            if (idx_s == CW'(i)) key_r[i*W +: W] <= in_data;
        end else begin
          for (int i = 0; i < DATA_WORDS; i++)
            if (idx_s == CW'(i)) plain_r[i*W +: W] <= in_data;
          if (last_in_s) enc_dec_r <= in_enc_dec;
        end
      end
    end
  end

  assign in_ready = (in_state_r == COLLECT);
  assign newData  = new_data_r;
  assign newKey   = new_key_r;
  assign plain    = plain_r;
  assign key      = key_r;
  assign enc_dec  = enc_dec_r;

  // output FSM next state; doneData is only looked at while idle
  always_comb begin
    o_state_s  = o_state_r;
    sh_load_s  = 1'b0;
    sh_shift_s = 1'b0;
    case (o_state_r)
      O_IDLE: begin
        if (doneData) begin
          o_state_s = O_SEND;
          sh_load_s = 1'b1;
        end else begin
          o_state_s = O_IDLE;
        end
      end
      O_SEND: begin
        if (out_ready) begin
          sh_shift_s = 1'b1;
          o_state_s  = sh_last_s ? O_IDLE : O_SEND;
        end else begin
          o_state_s = O_SEND;
        end
      end
      default: o_state_s = O_IDLE;
    endcase
  end

  // output FSM state and handshake registers
  always_ff @(posedge clk or negedge nR) begin
    if (!nR) begin
      o_state_r   <= O_IDLE;
      read_data_r <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      o_state_r   <= o_state_s;
      read_data_r <= sh_load_s;
      out_valid_r <= (o_state_s == O_SEND);
    end
  end

  simon_word_shifter #(.WIDTH(2*N), .W(W)) u_unpack (
    .clk       (clk),
    .rst_n     (nR),
    .load      (sh_load_s),
    .load_data (cipher),
    .shift     (sh_shift_s),
    .word      (sh_word_s),
    .last      (sh_last_s)
  );

  assign readData  = read_data_r;
  assign out_valid = out_valid_r;
  assign out_data  = sh_word_s;

endmodule

// File: tb/tb_simon_bus_adapter.sv
// Directed self-checking bench for simon_bus_adapter at default parameters.
module tb_simon_bus_adapter;

  logic        clk = 1'b0;
  logic        nR = 1'b0;
  logic        in_valid = 1'b0, in_kind = 1'b0, in_enc_dec = 1'b0;
  logic [15:0] in_data = 16'h0;
  logic        in_ready, out_valid, out_ready = 1'b0;
  logic [15:0] out_data;
  logic        newData, newKey, ldData = 1'b0, ldKey = 1'b0, enc_dec;
  logic [95:0] plain, key, cipher = 96'h0;
  logic        doneData = 1'b0, readData;

  int checks = 0;
  int errors = 0;

  simon_bus_adapter dut (
    .clk(clk), .nR(nR),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_kind(in_kind), .in_enc_dec(in_enc_dec),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .newData(newData), .newKey(newKey), .ldData(ldData), .ldKey(ldKey),
    .enc_dec(enc_dec), .plain(plain), .key(key),
    .doneData(doneData), .readData(readData), .cipher(cipher)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic kind, input logic [15:0] d, input logic ed);
    chk("in_ready_collect", in_ready, 1'b1);
    in_valid = 1'b1; in_kind = kind; in_data = d; in_enc_dec = ed;
    step();
    in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    chk({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 16'h0);
    chk({tag, "_newData"}, newData, 1'b0);
    chk({tag, "_newKey"}, newKey, 1'b0);
    chk({tag, "_readData"}, readData, 1'b0);
    chk({tag, "_enc_dec"}, enc_dec, 1'b0);
    chk({tag, "_plain"}, plain, 96'h0);
    chk({tag, "_key"}, key, 96'h0);
  endtask

  logic [15:0] kw [6];
  logic [15:0] dw [6];
  logic [15:0] cw [6];
  logic [15:0] c2 [6];
  int idx, rd_cnt, cyc;

  initial begin
    kw = '{16'h0100, 16'h0302, 16'h0504, 16'h0908, 16'h0b0a, 16'h0d0c};
    dw = '{16'h7420, 16'h6568, 16'h7020, 16'h6c69, 16'h616c, 16'h2072};
    cw = '{16'hf082, 16'h3d8f, 16'h6906, 16'h62b4, 16'h07a4, 16'h6028};
    c2 = '{16'h1234, 16'h5678, 16'h9abc, 16'hdef0, 16'h0f1e, 16'h2d3c};

    // power-up reset
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    nR = 1'b1;
    step();

    // key burst
    for (int i = 0; i < 6; i++) begin
      chk("newKey_low_during_burst", newKey, 1'b0);
      send(1'b1, kw[i], 1'b0);
    end
    chk("newKey_after_6th", newKey, 1'b1);
    chk("in_ready_offer_k", in_ready, 1'b0);
    chk("key_value", key, 96'h0d0c0b0a0908050403020100);
    step(); step();
    chk("newKey_held", newKey, 1'b1);
    ldKey = 1'b1;
    step();
    ldKey = 1'b0;
    chk("newKey_released", newKey, 1'b0);
    chk("in_ready_after_ldKey", in_ready, 1'b1);

    // data burst, encrypt, ldData after 5 cycles; a stray ldKey must not release it
    for (int i = 0; i < 6; i++) send(1'b0, dw[i], 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("newData_held", newData, 1'b1);
      chk("in_ready_offer_d", in_ready, 1'b0);
      chk("plain_stable", plain, 96'h2072616c6c69702065687420);
      ldKey  = (i == 1);
      ldData = (i == 4);
      step();
    end
    ldData = 1'b0; ldKey = 1'b0;
    chk("newData_released", newData, 1'b0);
    chk("in_ready_after_ldData", in_ready, 1'b1);
    chk("enc_dec_latched", enc_dec, 1'b1);
    chk("plain_after_load", plain, 96'h2072616c6c69702065687420);

    // ciphertext readout with out_ready held high
    out_ready = 1'b1;
    cipher = 96'h602807a462b469063d8ff082;
    doneData = 1'b1;
    step();
    doneData = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("out_valid_stream", out_valid, 1'b1);
      chk("out_word", out_data, cw[k]);
      chk("readData_pulse", readData, (k == 0) ? 1'b1 : 1'b0);
      step();
    end
    chk("out_valid_done", out_valid, 1'b0);

    // same capture with out_ready toggling
    out_ready = 1'b0;
    doneData = 1'b1;
    step();
    doneData = 1'b0;
    idx = 0; rd_cnt = 0; cyc = 0;
    while (idx < 6 && cyc < 40) begin
      out_ready = cyc[0];
      chk("out_valid_toggle", out_valid, 1'b1);
      chk("out_word_toggle", out_data, cw[idx]);
      if (readData) rd_cnt++;
      if (out_ready) idx++;
      step();
      cyc++;
    end
    chk("toggle_all_words", idx, 6);
    chk("toggle_readData_once", rd_cnt, 1);
    chk("toggle_out_valid_done", out_valid, 1'b0);
    out_ready = 1'b1;

    // stray loads in COLLECT are ignored
    ldData = 1'b1; ldKey = 1'b1;
    step();
    ldData = 1'b0; ldKey = 1'b0;
    chk("stray_ld_newData", newData, 1'b0);
    chk("stray_ld_newKey", newKey, 1'b0);

    // partial data burst discarded by a key word; key count restarts at 1
    send(1'b0, 16'h1111, 1'b1);
    send(1'b0, 16'h2222, 1'b1);
    send(1'b0, 16'h3333, 1'b1);
    send(1'b1, 16'haaaa, 1'b0);
    send(1'b1, 16'hbbbb, 1'b0);
    send(1'b1, 16'hcccc, 1'b0);
    send(1'b1, 16'hdddd, 1'b0);
    send(1'b1, 16'heeee, 1'b0);
    chk("restart_newKey_early", newKey, 1'b0);
    chk("restart_newData", newData, 1'b0);
    send(1'b1, 16'hffff, 1'b0);
    chk("restart_newKey", newKey, 1'b1);
    chk("restart_key", key, 96'hffffeeeeddddccccbbbbaaaa);
    ldKey = 1'b1; step(); ldKey = 1'b0;
    for (int i = 0; i < 6; i++) send(1'b0, 16'(i + 1), 1'b0);
    chk("full_data_newData", newData, 1'b1);
    chk("full_data_plain", plain, 96'h000600050004000300020001);
    chk("full_data_enc_dec", enc_dec, 1'b0);

    // asynchronous reset while in OFFER_D
    #2 nR = 1'b0;
    #1 check_reset_outputs("reset_offer_d");
    @(negedge clk);
    nR = 1'b1;
    step();

    // asynchronous reset while in O_SEND
    cipher = 96'h2d3c0f1edef09abc56781234;
    doneData = 1'b1;
    step();
    doneData = 1'b0;
    chk("pre_reset_word0", out_data, c2[0]);
    step();
    #2 nR = 1'b0;
    #1 check_reset_outputs("reset_o_send");
    @(negedge clk);
    nR = 1'b1;
    step();
    chk("post_reset_out_valid", out_valid, 1'b0);

    // after reset: key burst and a full readout behave as from power-up
    for (int i = 0; i < 6; i++) send(1'b1, kw[i], 1'b0);
    chk("post_reset_newKey", newKey, 1'b1);
    chk("post_reset_key", key, 96'h0d0c0b0a0908050403020100);
    ldKey = 1'b1; step(); ldKey = 1'b0;
    doneData = 1'b1;
    step();
    doneData = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("post_reset_out_word", out_data, c2[k]);
      chk("post_reset_readData", readData, (k == 0) ? 1'b1 : 1'b0);
      step();
    end
    chk("post_reset_out_done", out_valid, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
